// File: rtl/qpi_cache_mem_arb_if.sv
// rtl/qpi_cache_mem_arb_if.sv - requester, response and RAM signal bundle for qpi_cache_mem_arb
interface qpi_cache_mem_arb_if #(
  parameter int NREQ = 2,
  parameter int AW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [4*NREQ-1:0]  req_wen;
  logic [AW*NREQ-1:0] req_addr;
  logic [32*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]    resp_valid;
  logic [31:0]        resp_rdata;
  logic [3:0]         mem_wen;
  logic [AW-1:0]      mem_addr;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;

  // Arbiter side
  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_wen, mem_addr, mem_wdata
  );

  // Requesters plus RAM side
  modport master (
    output req_valid, req_wen, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/qpi_cache_mem_arb.sv
// rtl/qpi_cache_mem_arb.sv - single-port RAM arbiter with clear sweep; QPI_MEM_ARB_FIXED_PRIO_EN selects fixed priority
module qpi_cache_mem_arb #(
  parameter int          NREQ     = 2,
  parameter int          WORDS    = 256,
  parameter logic [31:0] INIT_VAL = 32'h00000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  output logic                busy,
  qpi_cache_mem_arb_if.slave  bus
);
  localparam int AW = $clog2(WORDS);
  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] resp_valid_q;
  logic [AW-1:0]   addr_hold_q;
  logic [31:0]     wdata_hold_q;

  logic            gnt_any;
  logic [RW-1:0]   gnt_idx;
  logic            run_gnt;

`ifdef QPI_MEM_ARB_FIXED_PRIO_EN
  // Lowest-index valid requester wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        gnt_any = 1'b1;
        gnt_idx = RW'(i);
      end
    end
  end
`else
  logic [RW-1:0] rr_q, rr_d;
  logic [RW-1:0] cand;

  // First valid requester at or after the round-robin pointer, wrapping
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = RW'((int'(rr_q) + k) % NREQ);
      if (bus.req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Pointer moves past the granted requester; idle cycles leave it alone
  always_comb begin
    rr_d = rr_q;
    if (run_gnt) begin
      rr_d = (gnt_idx == RW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end
`endif

  assign run_gnt       = (state_q == ST_RUN) && gnt_any;
  assign bus.req_ready = run_gnt ? (NREQ'(1) << gnt_idx) : '0;
  assign busy          = (state_q == ST_CLEAR);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = bus.mem_rdata;

  // RAM port mux: sweep writes, granted request, or idle with address/data held
  always_comb begin
    bus.mem_wen   = 4'h0;
    bus.mem_addr  = addr_hold_q;
    bus.mem_wdata = wdata_hold_q;
    if (state_q == ST_CLEAR) begin
      bus.mem_wen   = 4'hF;
      bus.mem_addr  = cnt_q;
      bus.mem_wdata = INIT_VAL;
    end else if (gnt_any) begin
      bus.mem_wen   = bus.req_wen[int'(gnt_idx) * 4 +: 4];
      bus.mem_addr  = bus.req_addr[int'(gnt_idx) * AW +: AW];
      bus.mem_wdata = bus.req_wdata[int'(gnt_idx) * 32 +: 32];
    end
  end

  // Sweep walks every word once, then serves requests until a flush restarts it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      if (cnt_q == LAST_ADDR) state_d = ST_RUN;
      else                    cnt_d   = cnt_q + 1'b1;
    end else if (flush) begin
      state_d = ST_CLEAR;
      cnt_d   = '0;
    end
  end

  // State, sweep counter, response strobe and idle hold registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= '0;
      resp_valid_q <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= bus.req_ready;
      addr_hold_q  <= bus.mem_addr;
      wdata_hold_q <= bus.mem_wdata;
    end
  end
endmodule

// File: tb/tb_qpi_cache_mem_arb.sv
// tb/tb_qpi_cache_mem_arb.sv - self-checking bench for qpi_cache_mem_arb against a behavioural model
module tb_qpi_cache_mem_arb;
  localparam int          NREQ  = 2;
  localparam int          WORDS = 16;
  localparam int          AW    = $clog2(WORDS);
  localparam logic [31:0] INIT  = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic busy;

  qpi_cache_mem_arb_if #(.NREQ(NREQ), .AW(AW)) bus ();

  qpi_cache_mem_arb #(.NREQ(NREQ), .WORDS(WORDS), .INIT_VAL(INIT)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External single-port RAM, read-before-write
  logic [31:0] ram [WORDS];
  always @(posedge clk) begin
    bus.mem_rdata <= ram[bus.mem_addr];
    for (int b = 0; b < 4; b++)
      if (bus.mem_wen[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_clear;
  int          m_cnt;
  int          m_rr;
  logic [31:0] ref_mem [WORDS];
  logic [AW-1:0] last_addr;
  logic [31:0] last_wdata;
  int          acc_g;
  logic [NREQ-1:0] obs_ready;
  logic        obs_busy;
  logic [AW-1:0] obs_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
`ifdef QPI_MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (bus.req_valid[i]) return i;
`else
    for (int k = 0; k < NREQ; k++)
      if (bus.req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
`endif
    return -1;
  endfunction

  task automatic set_req(input int i, input bit v, input logic [3:0] w,
                         input logic [AW-1:0] a, input logic [31:0] d);
    bus.req_valid[i]          = v;
    bus.req_wen[4*i +: 4]     = w;
    bus.req_addr[AW*i +: AW]  = a;
    bus.req_wdata[32*i +: 32] = d;
  endtask

  // One clock cycle: check combinational outputs mid-cycle, advance model, check response
  task automatic step();
    int g;
    int a;
    logic [31:0] rd;
    logic [3:0]  w;
    logic [31:0] d;
    g  = -1;
    rd = '0;
    #3;
    obs_ready = bus.req_ready;
    obs_busy  = busy;
    obs_addr  = bus.mem_addr;
    if (m_clear) begin
      chk("clr_busy", busy, 1);
      chk("clr_ready", bus.req_ready, 0);
      chk("clr_wen", bus.mem_wen, 4'hF);
      chk("clr_addr", bus.mem_addr, m_cnt);
      chk("clr_wdata", bus.mem_wdata, INIT);
    end else begin
      g = pick();
      chk("run_busy", busy, 0);
      chk("run_ready", bus.req_ready, (g >= 0) ? (1 << g) : 0);
      if (g >= 0) begin
        chk("run_wen", bus.mem_wen, bus.req_wen[4*g +: 4]);
        chk("run_addr", bus.mem_addr, bus.req_addr[AW*g +: AW]);
        chk("run_wdata", bus.mem_wdata, bus.req_wdata[32*g +: 32]);
      end else begin
        chk("idle_wen", bus.mem_wen, 0);
        chk("idle_addr", bus.mem_addr, last_addr);
        chk("idle_wdata", bus.mem_wdata, last_wdata);
      end
    end
    @(posedge clk);
    #1;
    if (m_clear) begin
      ref_mem[m_cnt] = INIT;
      last_addr  = AW'(m_cnt);
      last_wdata = INIT;
      if (m_cnt == WORDS - 1) m_clear = 0;
      else m_cnt++;
    end else begin
      if (g >= 0) begin
        a  = int'(bus.req_addr[AW*g +: AW]);
        w  = bus.req_wen[4*g +: 4];
        d  = bus.req_wdata[32*g +: 32];
        rd = ref_mem[a];
        for (int b = 0; b < 4; b++) if (w[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        last_addr  = AW'(a);
        last_wdata = d;
        m_rr = (g + 1) % NREQ;
      end
      if (flush) begin
        m_clear = 1;
        m_cnt   = 0;
      end
    end
    acc_g = g;
    if (rst) begin
      m_clear = 1; m_cnt = 0; m_rr = 0; g = -1;
      last_addr = '0; last_wdata = '0;
    end
    chk("resp_valid", bus.resp_valid, (g >= 0) ? (1 << g) : 0);
    if (g >= 0) chk("resp_rdata", bus.resp_rdata, rd);
  endtask

  bit [NREQ-1:0] held;
  int exp_g;

  initial begin
    for (int i = 0; i < WORDS; i++) ram[i] = $urandom;
    bus.req_valid = '0;
    bus.req_wen   = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    m_clear = 1; m_cnt = 0; m_rr = 0; last_addr = '0; last_wdata = '0;

    // Reset state while rst still held
    step();
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_busy", obs_busy, 1);
    rst = 1'b0;

    // Sweep with both requesters waiting
    set_req(0, 1, 4'h0, 4'd1, 32'h0);
    set_req(1, 1, 4'h0, 4'd2, 32'h0);
    repeat (WORDS) step();
    chk("sweep_last_busy", obs_busy, 1);
    step();
    chk("sweep_first_grant", obs_ready, 2'b01);
    set_req(0, 0, 4'h0, 4'd0, 32'h0);
    step();
    set_req(1, 0, 4'h0, 4'd0, 32'h0);
    step();

    // Write then read
    set_req(0, 1, 4'hF, 4'd5, 32'hCAFEF00D);
    step();
    chk("wr_old_data", bus.resp_rdata, INIT);
    set_req(0, 1, 4'h0, 4'd5, 32'h0);
    step();
    chk("rd_new_data", bus.resp_rdata, 32'hCAFEF00D);

    // Byte merge
    set_req(0, 1, 4'hF, 4'd7, 32'h11223344);
    step();
    set_req(0, 1, 4'b0101, 4'd7, 32'hAABBCCDD);
    step();
    set_req(0, 1, 4'h0, 4'd7, 32'h0);
    step();
    chk("byte_merge", bus.resp_rdata, 32'h11BB33DD);
    set_req(0, 0, 4'h0, 4'd0, 32'h0);
    set_req(1, 1, 4'h0, 4'd3, 32'h0);
    step();
    set_req(1, 0, 4'h0, 4'd0, 32'h0);
    step();

    // Fairness
    set_req(0, 1, 4'h0, 4'd7, 32'h0);
    set_req(1, 1, 4'h0, 4'd5, 32'h0);
    for (int c = 0; c < 6; c++) begin
      step();
`ifdef QPI_MEM_ARB_FIXED_PRIO_EN
      chk("fair_grant", obs_ready, 2'b01);
`else
      chk("fair_grant", obs_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
`endif
    end
    set_req(0, 0, 4'h0, 4'd0, 32'h0);
    step();
    set_req(1, 0, 4'h0, 4'd0, 32'h0);
    step();

    // Flush overlapping a req1 read
    set_req(1, 1, 4'h0, 4'd7, 32'h0);
    flush = 1'b1;
    step();
    chk("flush_resp_valid", bus.resp_valid, 2'b10);
    chk("flush_resp_data", bus.resp_rdata, 32'h11BB33DD);
    flush = 1'b0;
    set_req(1, 0, 4'h0, 4'd0, 32'h0);
    step();
    chk("flush_busy", obs_busy, 1);
    repeat (WORDS - 1) step();
    step();
    chk("flush_sweep_done", obs_busy, 0);

    // Reset mid-sweep at counter 9
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (9) step();
    chk("pre_rst_addr", obs_addr, 8);
    rst = 1'b1;
    step();
    chk("midsweep_rst_addr", obs_addr, 9);
    rst = 1'b0;
    step();
    chk("restart_addr0", obs_addr, 0);
    chk("restart_resp", bus.resp_valid, 0);
    repeat (WORDS - 1) step();
    chk("restart_last_busy", obs_busy, 1);

    // Reset in RUN drops a pending response
    set_req(0, 1, 4'h0, 4'd5, 32'h0);
    step();
    rst = 1'b1;
    step();
    chk("rst_drop_resp", bus.resp_valid, 0);
    rst = 1'b0;
    set_req(0, 0, 4'h0, 4'd0, 32'h0);
    repeat (WORDS) step();

    // Randomized traffic with occasional flush and reset
    held = '0;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        bus.req_valid[i] = held[i] ? 1'b1 : 1'($urandom_range(0, 1));
        bus.req_wen[4*i +: 4]     = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        bus.req_addr[AW*i +: AW]  = AW'($urandom);
        bus.req_wdata[32*i +: 32] = $urandom;
      end
      flush = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 149) == 0);
      step();
      exp_g = acc_g;
      for (int i = 0; i < NREQ; i++)
        held[i] = bus.req_valid[i] && (exp_g != i) && !rst;
    end
    flush = 1'b0;
    rst   = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
